// File: rtl/delay_pipe_tap.sv
// Stallable, flushable multi-bit delay line with a runtime-selectable tap.
// Tracks per-stage valid bits and reports how many stages are occupied.
module delay_pipe_tap #(
    parameter int               WIDTH          = 32,
    parameter int               DEPTH          = 4,
    parameter logic [WIDTH-1:0] RESET          = '0,
    parameter bit               CLEAR_ON_FLUSH = 1'b0,
    parameter bit               MASK_INVALID   = 1'b0,
    parameter int               SELW           = (DEPTH > 0) ? $clog2(DEPTH + 1) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    input  logic [SELW-1:0]  sel,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic [SELW-1:0]  count
);

    if (DEPTH == 0) begin : g_bypass
        logic unused_ok;
        assign unused_ok = ^{clk, rst_n, en, flush, sel};
        assign out       = (MASK_INVALID && !in_valid) ? RESET : in;
        assign out_valid = in_valid;
        assign count     = '0;
    end else begin : g_pipe
        logic [WIDTH-1:0] d_q [DEPTH];
        logic [WIDTH-1:0] d_d [DEPTH];
        logic [DEPTH-1:0] v_q;
        logic [DEPTH-1:0] v_d;
        logic [SELW-1:0]  sel_sat;
        logic [SELW-1:0]  cnt;
        logic [WIDTH-1:0] tap_d;
        logic             tap_v;

        // Flush wins over en for valids; data still shifts unless cleared.
        always_comb begin
            d_d = d_q;
            v_d = v_q;
            if (en) begin
                d_d[0] = in;
                v_d[0] = in_valid;
                for (int k = 1; k < DEPTH; k++) begin
                    d_d[k] = d_q[k-1];
                    v_d[k] = v_q[k-1];
                end
            end
            if (flush) begin
                v_d = '0;
                if (CLEAR_ON_FLUSH) begin
                    for (int k = 0; k < DEPTH; k++) begin
                        d_d[k] = RESET;
                    end
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k < DEPTH; k++) begin
                    d_q[k] <= RESET;
                end
                v_q <= '0;
            end else begin
                for (int k = 0; k < DEPTH; k++) begin
                    d_q[k] <= d_d[k];
                end
                v_q <= v_d;
            end
        end

        assign sel_sat = (sel > SELW'(DEPTH)) ? SELW'(DEPTH) : sel;

        always_comb begin
            tap_d = in;
            tap_v = in_valid;
            for (int k = 0; k < DEPTH; k++) begin
                if (sel_sat == SELW'(k + 1)) begin
                    tap_d = d_q[k];
                    tap_v = v_q[k];
                end
            end
        end

        always_comb begin
            cnt = '0;
            for (int k = 0; k < DEPTH; k++) begin
                cnt = cnt + SELW'(v_q[k]);
            end
        end

        assign out       = (MASK_INVALID && !tap_v) ? RESET : tap_d;
        assign out_valid = tap_v;
        assign count     = cnt;
    end

endmodule

// File: tb/tb_delay_pipe_tap.sv
// Randomised and directed checks of delay_pipe_tap against a queue model.
// Three builds: plain, clear+mask, and a zero-depth bypass.
module tb_delay_pipe_tap;

    localparam logic [7:0] RV = 8'hA5;

    typedef struct {
        logic [7:0] d;
        logic       v;
    } ent_t;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       flush;
    logic [7:0] din;
    logic       in_valid;
    logic [2:0] sel;

    logic [7:0] out0, out1, out2;
    logic       ov0, ov1, ov2;
    logic [2:0] cnt0, cnt1;
    logic       cnt2;

    int tests;
    int fails;

    ent_t qa[$];
    ent_t qc[$];

    delay_pipe_tap #(
        .WIDTH(8), .DEPTH(4), .RESET(RV),
        .CLEAR_ON_FLUSH(1'b0), .MASK_INVALID(1'b0)
    ) u0 (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
        .in(din), .in_valid(in_valid), .sel(sel),
        .out(out0), .out_valid(ov0), .count(cnt0)
    );

    delay_pipe_tap #(
        .WIDTH(8), .DEPTH(4), .RESET(RV),
        .CLEAR_ON_FLUSH(1'b1), .MASK_INVALID(1'b1)
    ) u1 (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
        .in(din), .in_valid(in_valid), .sel(sel),
        .out(out1), .out_valid(ov1), .count(cnt1)
    );

    delay_pipe_tap #(
        .WIDTH(8), .DEPTH(0), .RESET(RV)
    ) u2 (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
        .in(din), .in_valid(in_valid), .sel(sel[0]),
        .out(out2), .out_valid(ov2), .count(cnt2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        ent_t e;
        e.d = RV;
        e.v = 1'b0;
        qa.delete();
        qc.delete();
        for (int i = 0; i < 4; i++) begin
            qa.push_back(e);
            qc.push_back(e);
        end
    endtask

    // The newest accepted sample is at index 0; a tap of k reads entry k-1.
    task automatic model_edge();
        ent_t e;
        e.d = din;
        e.v = in_valid;
        if (en) begin
            qa.push_front(e);
            void'(qa.pop_back());
            qc.push_front(e);
            void'(qc.pop_back());
        end
        if (flush) begin
            for (int i = 0; i < 4; i++) begin
                qa[i].v = 1'b0;
                qc[i].v = 1'b0;
                qc[i].d = RV;
            end
        end
    endtask

    task automatic compare_all();
        int         s;
        int         n;
        logic [7:0] ea;
        logic       eav;
        logic [7:0] ec;
        s = (int'(sel) > 4) ? 4 : int'(sel);
        n = 0;
        for (int i = 0; i < 4; i++) n += int'(qa[i].v);
        if (s == 0) begin
            ea  = din;
            eav = in_valid;
            ec  = in_valid ? din : RV;
        end else begin
            ea  = qa[s-1].d;
            eav = qa[s-1].v;
            ec  = qc[s-1].v ? qc[s-1].d : RV;
        end
        check("u0_out", 32'(out0), 32'(ea));
        check("u0_vld", 32'(ov0), 32'(eav));
        check("u0_cnt", 32'(cnt0), 32'(n));
        check("u1_out", 32'(out1), 32'(ec));
        check("u1_vld", 32'(ov1), 32'(eav));
        check("u1_cnt", 32'(cnt1), 32'(n));
        check("u2_out", 32'(out2), 32'(din));
        check("u2_vld", 32'(ov2), 32'(in_valid));
        check("u2_cnt", 32'(cnt2), 32'(0));
    endtask

    // Called at a falling edge: apply inputs, check, then take one edge.
    task automatic cyc(input logic e, input logic f, input logic [7:0] d,
                       input logic iv, input logic [2:0] s);
        en       = e;
        flush    = f;
        din      = d;
        in_valid = iv;
        sel      = s;
        #1 compare_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        rst_n    = 1'b0;
        en       = 1'b0;
        flush    = 1'b0;
        din      = 8'h00;
        in_valid = 1'b0;
        sel      = 3'd3;
        model_reset();
        @(negedge clk);
        #1 compare_all();
        check("rst_cnt", 32'(cnt0), 32'(0));
        check("rst_out3", 32'(out0), 32'(RV));
        rst_n = 1'b1;
        @(negedge clk);

        // Fixed delay of four with a ramping input.
        for (int i = 1; i <= 4; i++) begin
            cyc(1'b1, 1'b0, 8'(i), 1'b1, 3'd4);
            check("ramp_cnt", 32'(cnt0), 32'(i));
        end
        en = 1'b0;
        sel = 3'd4;
        #1 check("delay4_out", 32'(out0), 32'h01);
        check("delay4_vld", 32'(ov0), 32'(1));

        // Tap switching and saturation over held contents 04,03,02,01.
        din = 8'h77;
        sel = 3'd0;
        #1 check("tap0", 32'(out0), 32'h77);
        sel = 3'd1;
        #1 check("tap1", 32'(out0), 32'h04);
        sel = 3'd3;
        #1 check("tap3", 32'(out0), 32'h02);
        sel = 3'd7;
        #1 check("tap7", 32'(out0), 32'h01);
        @(negedge clk);

        // Async reset between edges with a full valid pipe.
        sel = 3'd3;
        #2 rst_n = 1'b0;
        #1 check("arst_cnt", 32'(cnt0), 32'(0));
        check("arst_out", 32'(out0), 32'(RV));
        check("arst_vld", 32'(ov0), 32'(0));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Two stall cycles after the second edge delay the first sample.
        cyc(1'b1, 1'b0, 8'h01, 1'b1, 3'd4);
        cyc(1'b1, 1'b0, 8'h02, 1'b1, 3'd4);
        cyc(1'b0, 1'b0, 8'h03, 1'b1, 3'd4);
        cyc(1'b0, 1'b0, 8'h03, 1'b1, 3'd4);
        check("stall_cnt", 32'(cnt0), 32'(2));
        cyc(1'b1, 1'b0, 8'h03, 1'b1, 3'd4);
        cyc(1'b1, 1'b0, 8'h04, 1'b1, 3'd4);
        en = 1'b0;
        #1 check("stall_out", 32'(out0), 32'h01);
        check("stall_full", 32'(cnt0), 32'(4));

        // Flush a full pipe while feeding a valid sample.
        @(negedge clk);
        cyc(1'b1, 1'b1, 8'hFF, 1'b1, 3'd4);
        en = 1'b0;
        for (int s = 1; s <= 4; s++) begin
            sel = 3'(s);
            #1 check("flush_vld", 32'(ov0), 32'(0));
            check("flush_clr", 32'(out1), 32'(RV));
        end
        check("flush_cnt", 32'(cnt0), 32'(0));

        // Masked bypass with an invalid input.
        sel = 3'd0;
        din = 8'h3C;
        in_valid = 1'b0;
        #1 check("mask_byp", 32'(out1), 32'(RV));
        check("d0_byp", 32'(out2), 32'h3C);
        @(negedge clk);

        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            cyc(($urandom_range(3) != 0), ($urandom_range(11) == 0),
                8'($urandom), 1'($urandom), 3'($urandom_range(7)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
